// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter.
//   WB_DATA_W / WB_ADDR_W : default register data and address widths
//   wb_state_e            : arbiter state (IDLE, PEND, FORCE)
//   wb_entry_t            : one queued secondary write {addr, data} at default widths
package wb_arb_pkg;

  localparam int WB_DATA_W = 8;
  localparam int WB_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Parameterised synchronous FIFO with first-word-fall-through read port.
// Ports:
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   push, din     : write strobe and data (ignored when full)
//   pop, dout     : read strobe (ignored when empty) and current head entry
//   full, empty   : occupancy flags
//   count         : exact occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so pointers wrap by plain overflow.
module wb_sync_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback
// (fixed priority, never stalled by this block) and a queued secondary
// writer (loader / debug poke) that drains in idle writeback slots.
// A starvation guard raises pipe_stall when the queue head waits too long.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   pipe_we/pipe_addr/pipe_data     : writeback from the EX/WB register
//   sec_valid/sec_ready/sec_addr/sec_data : secondary request handshake
//   rf_we/rf_addr/rf_data           : register-file write port
//   pipe_stall                      : stall request to fetch/decode
//   fifo_count, busy                : queue occupancy / non-empty
//   sec_wr_total, stall_cycles      : saturating statistics (WB_ARB_STATS_EN only)
// Handshake: a secondary write is accepted on any rising edge where
// sec_valid && sec_ready; sec_ready depends only on the queue being not
// full (a same-cycle pop does not open a slot) and reset being low.
// Optional feature macro: WB_ARB_STATS_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = WB_DATA_W,
  parameter int ADDR_W       = WB_ADDR_W,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [ADDR_W-1:0] sec_addr,
  input  logic [DATA_W-1:0] sec_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              pipe_stall,
  output logic [CW-1:0]     fifo_count,
  output logic              busy
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       sec_wr_total,
  output logic [15:0]       stall_cycles
`endif
);

  logic [ADDR_W+DATA_W-1:0] head;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     last_out;
  logic [7:0]               wait_cnt;
  wb_state_e                state;

  assign sec_ready = !full && !reset;
  assign push      = sec_valid && sec_ready;
  // The pipeline always wins; the queue only drains in bubbles.
  assign pop       = !pipe_we && !empty;
  assign busy      = !empty;
  // Queue becomes empty at this edge.
  assign last_out  = pop && !push && (fifo_count == CW'(1));

  wb_sync_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({sec_addr, sec_data}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (reset) begin
      rf_we = 1'b0;
    end else if (pipe_we) begin
      rf_we   = 1'b1;
      rf_addr = pipe_addr;
      rf_data = pipe_data;
    end else if (!empty) begin
      rf_we   = 1'b1;
      {rf_addr, rf_data} = head;
    end
  end

  // Age of the current head in cycles without a pop; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (pop || empty) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 8'(STARVE_LIMIT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pipe_stall <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push) state <= PEND;
        end
        PEND: begin
          if (last_out) begin
            state <= IDLE;
          end else if (!pop && wait_cnt == 8'(STARVE_LIMIT - 1)) begin
            state      <= FORCE;
            pipe_stall <= 1'b1;
          end
        end
        FORCE: begin
          // Stall holds until the starving head finally drains.
          if (pop) begin
            state      <= last_out ? IDLE : PEND;
            pipe_stall <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pipe_stall <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_wr_total <= '0;
      stall_cycles <= '0;
    end else begin
      if (pop && sec_wr_total != 16'hFFFF) sec_wr_total <= sec_wr_total + 16'd1;
      if (pipe_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       pipe_we;
  logic [2:0] pipe_addr;
  logic [7:0] pipe_data;
  logic       sec_valid;
  logic       sec_ready;
  logic [2:0] sec_addr;
  logic [7:0] sec_data;
  logic       rf_we;
  logic [2:0] rf_addr;
  logic [7:0] rf_data;
  logic       pipe_stall;
  logic [2:0] fifo_count;
  logic       busy;
`ifdef WB_ARB_STATS_EN
  logic [15:0] sec_wr_total;
  logic [15:0] stall_cycles;
`endif

  wb_port_arbiter #(
    .DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready),
    .sec_addr(sec_addr), .sec_data(sec_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .pipe_stall(pipe_stall), .fifo_count(fifo_count), .busy(busy)
`ifdef WB_ARB_STATS_EN
    , .sec_wr_total(sec_wr_total), .stall_cycles(stall_cycles)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;

  wb_entry_t exp_q[$];   // queued secondary writes in acceptance order
  int        m_wait;     // cycles the head has waited without a pop
  bit        m_stall;
  int        m_wr;       // secondary writes performed since reset
  int        m_stc;      // cycles with stall high since reset

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_wait  = 0;
    m_stall = 0;
    m_wr    = 0;
    m_stc   = 0;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, checks every output against the model
  // mid-cycle, then advances the model across the rising edge.
  task automatic step(input logic pw, input logic [2:0] pa, input logic [7:0] pd,
                      input logic sv, input logic [2:0] sa, input logic [7:0] sd);
    logic       e_we;
    logic [2:0] e_addr;
    logic [7:0] e_data;
    bit         do_pop;
    bit         do_push;
    int         size0;
    pipe_we = pw; pipe_addr = pa; pipe_data = pd;
    sec_valid = sv; sec_addr = sa; sec_data = sd;
    size0 = exp_q.size();
    if (pw) begin
      e_we = 1'b1; e_addr = pa; e_data = pd;
    end else if (size0 > 0) begin
      e_we = 1'b1; e_addr = exp_q[0].addr; e_data = exp_q[0].data;
    end else begin
      e_we = 1'b0; e_addr = '0; e_data = '0;
    end
    @(negedge clk);
    check("rf_we",      32'(rf_we),      32'(e_we));
    check("rf_addr",    32'(rf_addr),    32'(e_addr));
    check("rf_data",    32'(rf_data),    32'(e_data));
    check("sec_ready",  32'(sec_ready),  32'(size0 < DEPTH));
    check("fifo_count", 32'(fifo_count), 32'(size0));
    check("busy",       32'(busy),       32'(size0 > 0));
    check("pipe_stall", 32'(pipe_stall), 32'(m_stall));
    @(posedge clk);
    do_pop  = !pw && size0 > 0;
    do_push = sv && size0 < DEPTH;
    if (m_stall) m_stc++;
    if (do_pop) begin
      void'(exp_q.pop_front());
      m_wr++;
    end
    if (do_push) exp_q.push_back('{addr: sa, data: sd});
    if (do_pop || size0 == 0) m_wait = 0;
    else m_wait++;
    m_stall = do_pop ? 1'b0 : (m_stall || m_wait >= STARVE_LIMIT);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    pipe_we = 0; pipe_addr = 0; pipe_data = 0;
    sec_valid = 0; sec_addr = 0; sec_data = 0;
    model_clear();
    #3;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(sec_ready),  32'd0);
    check("rst_stall", 32'(pipe_stall), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(sec_ready), 32'd1);

    // Idle drain: push into an empty queue, written on the following cycle.
    step(1'b0, 3'd0, 8'd0, 1'b1, 3'd5, 8'hA5);
    pipe_we = 1'b0; sec_valid = 1'b0;
    #1;
    check("drain_we",   32'(rf_we),   32'd1);
    check("drain_addr", 32'(rf_addr), 32'd5);
    check("drain_data", 32'(rf_data), 32'hA5);
    idle_step();
    check("drain_empty", 32'(fifo_count), 32'd0);

    // Priority and ordering.
    step(1'b1, 3'd1, 8'd1, 1'b1, 3'd2, 8'd22);
    step(1'b1, 3'd1, 8'd2, 1'b1, 3'd3, 8'd33);
    step(1'b1, 3'd2, 8'd11, 1'b0, 3'd0, 8'd0);
    idle_step();
    idle_step();
    idle_step();

    // Full boundary with the pipeline holding the port.
    for (int i = 0; i < 4; i++) step(1'b1, 3'd7, 8'(i), 1'b1, 3'(i), 8'(8'h40 + i));
    check("full_ready", 32'(sec_ready), 32'd0);
    step(1'b1, 3'd7, 8'h55, 1'b1, 3'd6, 8'h66);
    check("full_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 5; i++) idle_step();

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 8'(i), 1'b1, 3'(i), 8'(i + 1));
    pipe_we = 1'b1; sec_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_stall", 32'(pipe_stall), 32'd0);
    check("arst_rf_we", 32'(rf_we),      32'd0);
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("arst_ready", 32'(sec_ready), 32'd1);

    // Starvation: one entry, pipeline busy every cycle.
    apply_reset();
    step(1'b1, 3'd1, 8'h10, 1'b1, 3'd6, 8'h77);
    for (int i = 1; i <= STARVE_LIMIT; i++) begin
      step(1'b1, 3'd1, 8'(i), 1'b0, 3'd0, 8'd0);
      if (i == STARVE_LIMIT - 1) check("starve_pre", 32'(pipe_stall), 32'd0);
    end
    check("starve_stall", 32'(pipe_stall), 32'd1);
    step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
    check("starve_release", 32'(pipe_stall), 32'd0);
`ifdef WB_ARB_STATS_EN
    check("stat_wr_total", 32'(sec_wr_total), 32'(m_wr));
    check("stat_stall",    32'(stall_cycles), 32'(m_stc));
    check("stat_wr_one",   32'(sec_wr_total), 32'd1);
`endif

    // Randomised traffic, pipeline biased busy to exercise the guard.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 70, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 45, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
`ifdef WB_ARB_STATS_EN
    check("rand_wr_total", 32'(sec_wr_total), 32'(m_wr));
    check("rand_stall",    32'(stall_cycles), 32'(m_stc));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion before %0t", $time);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
